// File: rtl/req_dispatch_6.sv
// Six-way request dispatcher: latches request lines, raises Irq, offers one source at a time
// round-robin via Valid/Id/Ready and returns a one-cycle one-hot Ack to the claimed source.
module req_dispatch_6 #(
  parameter logic [5:0] BubblesMask = 6'b000000,
  parameter logic [5:0] EdgeMask    = 6'b000000
) (
  input  logic       Clock,
  input  logic       nReset,
  input  logic [5:0] Request,
  input  logic [5:0] Enable,
  output logic       Irq,
  output logic       Valid,
  output logic [2:0] Id,
  input  logic       Ready,
  output logic [5:0] Ack
);

  typedef enum logic [1:0] {IDLE, OFFER, ACK} state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [5:0] r_s_in;
  logic [5:0] r_s_in_d;
  logic [5:0] r_pending;
  logic [5:0] r_in_service;
  logic [2:0] r_ptr;
  logic [2:0] r_id;

  logic       w_claim;
  logic [5:0] w_claim_vec;
  logic [5:0] w_set;
  logic [5:0] w_pending_nxt;
  logic [5:0] w_in_service_nxt;
  logic [5:0] w_avail;
  logic [7:0] w_avail8;
  logic       w_found;
  logic [2:0] w_pick;
  logic [2:0] w_ptr_nxt;
  logic [2:0] w_id_nxt;

  assign w_claim     = (r_state == OFFER) && Ready;
  assign w_claim_vec = w_claim ? (6'b000001 << r_id) : 6'b000000;

  // A level source being claimed this cycle must not re-arm from its still-high input;
  // InService only takes over from the next cycle.
  assign w_set = (EdgeMask & r_s_in & ~r_s_in_d)
               | (~EdgeMask & r_s_in & ~r_in_service & ~w_claim_vec);

  assign w_pending_nxt    = (r_pending & ~w_claim_vec) | w_set;
  assign w_in_service_nxt = ~EdgeMask & (r_in_service | w_claim_vec) & r_s_in;

  assign w_avail  = r_pending & Enable;
  assign w_avail8 = {2'b00, w_avail};
  assign Irq      = |w_avail;

  always_comb begin : rr_pick
    logic [3:0] v_idx;
    v_idx   = 4'd0;
    w_found = 1'b0;
    w_pick  = 3'd0;
    for (int j = 0; j < 6; j++) begin
      v_idx = {1'b0, r_ptr} + 4'(j);
      if (v_idx >= 4'd6) v_idx = v_idx - 4'd6;
      if (!w_found && w_avail8[v_idx[2:0]]) begin
        w_found = 1'b1;
        w_pick  = v_idx[2:0];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_id_nxt    = r_id;
    w_ptr_nxt   = r_ptr;
    Valid       = 1'b0;
    Ack         = 6'b000000;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_id_nxt    = w_pick;
          w_state_nxt = OFFER;
        end
      end
      OFFER: begin
        Valid = 1'b1;
        if (Ready) begin
          w_ptr_nxt   = (r_id == 3'd5) ? 3'd0 : r_id + 3'd1;
          w_state_nxt = ACK;
        end
      end
      ACK: begin
        Ack         = 6'b000001 << r_id;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign Id = r_id;

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      r_state      <= IDLE;
      r_s_in       <= 6'b000000;
      r_s_in_d     <= 6'b000000;
      r_pending    <= 6'b000000;
      r_in_service <= 6'b000000;
      r_ptr        <= 3'd0;
      r_id         <= 3'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_s_in       <= Request ^ BubblesMask;
      r_s_in_d     <= r_s_in;
      r_pending    <= w_pending_nxt;
      r_in_service <= w_in_service_nxt;
      r_ptr        <= w_ptr_nxt;
      r_id         <= w_id_nxt;
    end
  end

endmodule

// File: tb/tb_req_dispatch_6.sv
// Directed bench for req_dispatch_6: a default-mask instance (A) and a bubbled/edge instance (B).
module tb_req_dispatch_6;

  logic       clk;
  logic       nReset;
  logic [5:0] reqA, enA, reqB, enB;
  logic       rdyA, rdyB;
  logic       irqA, vldA, irqB, vldB;
  logic [2:0] idA, idB;
  logic [5:0] ackA, ackB;

  int total = 0;
  int bad   = 0;

  req_dispatch_6 u_a (
    .Clock(clk), .nReset(nReset), .Request(reqA), .Enable(enA),
    .Irq(irqA), .Valid(vldA), .Id(idA), .Ready(rdyA), .Ack(ackA)
  );

  req_dispatch_6 #(.BubblesMask(6'h01), .EdgeMask(6'h05)) u_b (
    .Clock(clk), .nReset(nReset), .Request(reqB), .Enable(enB),
    .Irq(irqB), .Valid(vldB), .Id(idB), .Ready(rdyB), .Ack(ackB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] req;
    logic [5:0] en;
    logic       rdy;
    logic       irq;
    logic       vld;
    logic [2:0] id;
    logic [5:0] ack;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    nReset = 1'b0;
    reqA = 6'h00; enA = 6'h3F; rdyA = 1'b0;
    reqB = 6'h01; enB = 6'h3F; rdyB = 1'b0;
    tick();
    tick();
    nReset = 1'b1;
  endtask

  vec_t rr[15];

  initial begin
    int offers, acks;
    logic [2:0] last_id;
    logic [5:0] last_ack;
    logic seen;

    // Round-robin over level sources 1,3,4 with Ready held high, then a drop/re-raise.
    rr[0]  = '{6'h1A, 6'h3F, 1'b1, 1'b0, 1'b0, 3'd0, 6'h00};
    rr[1]  = '{6'h1A, 6'h3F, 1'b1, 1'b1, 1'b0, 3'd0, 6'h00};
    rr[2]  = '{6'h1A, 6'h3F, 1'b1, 1'b1, 1'b1, 3'd1, 6'h00};
    rr[3]  = '{6'h1A, 6'h3F, 1'b1, 1'b1, 1'b0, 3'd1, 6'h02};
    rr[4]  = '{6'h1A, 6'h3F, 1'b1, 1'b1, 1'b0, 3'd1, 6'h00};
    rr[5]  = '{6'h1A, 6'h3F, 1'b1, 1'b1, 1'b1, 3'd3, 6'h00};
    rr[6]  = '{6'h1A, 6'h3F, 1'b1, 1'b1, 1'b0, 3'd3, 6'h08};
    rr[7]  = '{6'h1A, 6'h3F, 1'b1, 1'b1, 1'b0, 3'd3, 6'h00};
    rr[8]  = '{6'h1A, 6'h3F, 1'b1, 1'b1, 1'b1, 3'd4, 6'h00};
    rr[9]  = '{6'h1A, 6'h3F, 1'b1, 1'b0, 1'b0, 3'd4, 6'h10};
    rr[10] = '{6'h00, 6'h3F, 1'b1, 1'b0, 1'b0, 3'd4, 6'h00};
    rr[11] = '{6'h1A, 6'h3F, 1'b1, 1'b0, 1'b0, 3'd4, 6'h00};
    rr[12] = '{6'h1A, 6'h3F, 1'b1, 1'b1, 1'b0, 3'd4, 6'h00};
    rr[13] = '{6'h1A, 6'h3F, 1'b1, 1'b1, 1'b1, 3'd1, 6'h00};
    rr[14] = '{6'h1A, 6'h3F, 1'b1, 1'b1, 1'b0, 3'd1, 6'h02};

    // Reset held while requests toggle
    nReset = 1'b0;
    reqA = 6'h00; enA = 6'h3F; rdyA = 1'b0;
    reqB = 6'h01; enB = 6'h3F; rdyB = 1'b0;
    for (int i = 0; i < 4; i++) begin
      reqA = (i % 2 == 1) ? 6'h3F : 6'h00;
      tick();
      chk($sformatf("rst%0d_outs", i), {irqA, vldA, idA, ackA}, 32'h0);
    end
    reqA = 6'h3F;
    tick();
    nReset = 1'b1;
    tick();
    chk("rel_e1_vld", {irqA, vldA}, {1'b0, 1'b0});
    tick();
    chk("rel_e2_irq_vld", {irqA, vldA}, {1'b1, 1'b0});
    tick();
    chk("rel_e3_offer", {vldA, idA}, {1'b1, 3'd0});
    // Asynchronous reset mid-offer drops it without waiting for a clock edge
    #2;
    nReset = 1'b0;
    #1;
    chk("async_rst_drop", {irqA, vldA, idA, ackA}, 32'h0);
    tick();
    chk("async_rst_noack", {vldA, ackA}, 32'h0);

    // Round-robin table
    do_reset();
    for (int r = 0; r < 15; r++) begin
      reqA = rr[r].req; enA = rr[r].en; rdyA = rr[r].rdy;
      tick();
      chk($sformatf("rr%0d_irq", r), irqA, rr[r].irq);
      chk($sformatf("rr%0d_vld", r), vldA, rr[r].vld);
      chk($sformatf("rr%0d_id", r),  idA,  rr[r].id);
      chk($sformatf("rr%0d_ack", r), ackA, rr[r].ack);
    end

    // Bubbled edge source 0 on instance B: one falling Request edge gives one offer
    do_reset();
    tick(); tick(); tick();
    chk("edge_idle", {irqB, vldB}, 32'h0);
    reqB = 6'h00; rdyB = 1'b1;
    offers = 0; acks = 0; last_id = 3'd7; last_ack = 6'h00;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (vldB) begin offers++; last_id = idB; end
      if (ackB != 6'h00) begin acks++; last_ack = ackB; end
    end
    chk("edge_offers", offers, 1);
    chk("edge_id", last_id, 3'd0);
    chk("edge_acks", acks, 1);
    chk("edge_ackval", last_ack, 6'h01);

    // Level source 2: not re-offered while high, offered again after a drop
    do_reset();
    reqA = 6'h04; rdyA = 1'b1;
    offers = 0; last_id = 3'd7;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (vldA) begin offers++; last_id = idA; end
    end
    chk("lvl_offers", offers, 1);
    chk("lvl_id", last_id, 3'd2);
    chk("lvl_irq_quiet", irqA, 1'b0);
    reqA = 6'h00;
    tick();
    reqA = 6'h04;
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      tick();
      if (vldA) seen = 1'b1;
    end
    chk("lvl_reoffer_seen", seen, 1'b1);
    chk("lvl_reoffer_id", idA, 3'd2);

    // Stall with Enable removed, then claim of 5 and wrap of the pointer to 0
    do_reset();
    reqA = 6'h20;
    tick(); tick(); tick();
    chk("stall_offer", {vldA, idA}, {1'b1, 3'd5});
    enA = 6'h00; reqA = 6'h23;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("stall%0d_hold", i), {vldA, idA, ackA}, {1'b1, 3'd5, 6'h00});
    end
    chk("stall_irq_off", irqA, 1'b0);
    rdyA = 1'b1; enA = 6'h3F;
    tick();
    chk("stall_ack", {vldA, ackA}, {1'b0, 6'h20});
    tick();
    tick();
    chk("wrap_offer", {vldA, idA}, {1'b1, 3'd0});

    // Edge source 2 re-fires in the claim cycle: pending survives, offered again
    do_reset();
    reqB = 6'h05;
    tick(); tick(); tick();
    chk("coll_offer1", {vldB, idB}, {1'b1, 3'd2});
    reqB = 6'h01;
    tick();
    reqB = 6'h05;
    tick();
    rdyB = 1'b1;
    tick();
    chk("coll_ack1", {ackB, irqB}, {6'h04, 1'b1});
    tick();
    chk("coll_idle", {vldB, irqB}, {1'b0, 1'b1});
    tick();
    chk("coll_offer2", {vldB, idB}, {1'b1, 3'd2});
    tick();
    chk("coll_ack2", {ackB, irqB}, {6'h04, 1'b0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got running expected done");
    $fatal(1);
  end

endmodule
